// File: rtl/instr_byte_sequencer.sv
// Byte-serial front end for the single-cycle RV32 datapath: assembles an instruction
// from pin bytes, issues a one-cycle step, then streams the ALU result back out.
module instr_byte_sequencer #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [XLEN-1:0]   instr,
    output logic              step,
    input  logic [XLEN-1:0]   alu_result,
    output logic [BYTE_W-1:0] byte_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int unsigned NB    = XLEN / BYTE_W;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_EXEC,
        S_DRAIN
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  oidx_q;
    logic [XLEN-1:0]   shift_q;
    logic [XLEN-1:0]   shift_d;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    // Current byte merged into its slot so the final accept can load instr directly.
    always_comb begin
        shift_d = shift_q;
        shift_d[idx_q*BYTE_W +: BYTE_W] = byte_in;
    end

    assign byte_ready  = (state_q == S_LOAD);
    assign step        = (state_q == S_EXEC);
    assign out_valid   = (state_q == S_DRAIN);
    assign busy        = (state_q != S_LOAD);
    assign accept      = byte_valid & byte_ready;
    assign instr       = instr_q;
    assign instr_count = cnt_q;
    assign byte_out    = out_valid ? result_q[oidx_q*BYTE_W +: BYTE_W] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            idx_q    <= '0;
            oidx_q   <= '0;
            shift_q  <= '0;
            instr_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        shift_q <= shift_d;
                        if (idx_q == LAST) begin
                            instr_q <= shift_d;
                            idx_q   <= '0;
                            state_q <= S_EXEC;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    result_q <= alu_result;
                    cnt_q    <= cnt_q + 1'b1;
                    state_q  <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (oidx_q == LAST) begin
                            oidx_q  <= '0;
                            state_q <= S_LOAD;
                        end else begin
                            oidx_q <= oidx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_byte_sequencer.sv
// Scoreboard bench for instr_byte_sequencer; a narrow-counter twin instance shares
// the stimulus so counter wrap is reachable in a short run.
module tb_instr_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] instr;
    logic        step;
    logic [31:0] alu_result;
    logic [7:0]  byte_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] instr_count;

    logic        s_byte_ready, s_step, s_out_valid, s_busy;
    logic [31:0] s_instr, s_alu_result;
    logic [7:0]  s_byte_out;
    logic [2:0]  s_count;

    int          total = 0;
    int          bad   = 0;
    int unsigned steps = 0;
    logic [31:0] exp_instr_q[$];
    logic [7:0]  exp_byte_q[$];

    always #5 clk = ~clk;

    // Datapath stub: ADDI-style opcodes yield the sign-extended immediate.
    function automatic logic [31:0] alu_stub(input logic [31:0] i);
        if (i[6:0] == 7'h13) return {{20{i[31]}}, i[31:20]};
        return ~i ^ 32'h1357_9BDF;
    endfunction

    assign alu_result   = alu_stub(instr);
    assign s_alu_result = alu_stub(s_instr);

    instr_byte_sequencer #(.XLEN(32), .BYTE_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .instr(instr), .step(step), .alu_result(alu_result),
        .byte_out(byte_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .instr_count(instr_count)
    );

    instr_byte_sequencer #(.XLEN(32), .BYTE_W(8), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(s_byte_ready), .instr(s_instr), .step(s_step), .alu_result(s_alu_result),
        .byte_out(s_byte_out), .out_valid(s_out_valid), .out_ready(out_ready),
        .busy(s_busy), .instr_count(s_count)
    );

    task automatic run_instr(input logic [31:0] w, input int unsigned gap_pct,
                             input int unsigned stall_pct, input int unsigned hold,
                             input bit busy_valid);
        logic [31:0] res, exp_i;
        logic [7:0]  exp_b;
        int unsigned got;
        int unsigned cyc;
        bit          sent;
        res = alu_stub(w);
        exp_instr_q.push_back(w);
        for (int b = 0; b < 4; b++) exp_byte_q.push_back(res[b*8 +: 8]);

        for (int b = 0; b < 4; b++) begin
            sent = 1'b0;
            for (int t = 0; t < 64 && !sent; t++) begin
                @(negedge clk);
                total++;
                if (byte_ready !== 1'b1 || busy !== 1'b0 || step !== 1'b0 || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL load_state: ready=%b busy=%b step=%b ovalid=%b required 1 0 0 0",
                             byte_ready, busy, step, out_valid);
                end
                if (t < 63 && $urandom_range(99) < gap_pct) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'hCC;
                end else begin
                    byte_valid = 1'b1;
                    byte_in    = w[b*8 +: 8];
                    sent       = 1'b1;
                end
            end
        end

        @(negedge clk);
        byte_valid = busy_valid;
        byte_in    = 8'hEE;
        exp_i      = exp_instr_q.pop_front();
        total++;
        if (step !== 1'b1 || instr !== exp_i || byte_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL exec: step=%b instr=%h ready=%b ovalid=%b busy=%b required 1 %h 0 0 1",
                     step, instr, byte_ready, out_valid, busy, exp_i);
        end
        steps++;

        got = 0;
        for (cyc = 0; cyc < 200 && got < 4; cyc++) begin
            @(negedge clk);
            exp_b = exp_byte_q[0];
            total++;
            if (out_valid !== 1'b1 || step !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b1 ||
                byte_out !== exp_b || instr !== exp_i) begin
                bad++;
                $display("FAIL drain: ovalid=%b step=%b ready=%b busy=%b byte=%h instr=%h required 1 0 0 1 %h %h",
                         out_valid, step, byte_ready, busy, byte_out, instr, exp_b, exp_i);
            end
            if (cyc < hold) out_ready = 1'b0;
            else            out_ready = ($urandom_range(99) >= stall_pct) || (cyc > 150);
            if (out_ready) begin
                void'(exp_byte_q.pop_front());
                got++;
            end
        end
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL drain_timeout: bytes=%0d required 4", got);
        end
        total++;
        if (instr_count !== 16'(steps) || s_count !== 3'(steps)) begin
            bad++;
            $display("FAIL count: cnt=%h small=%h required %h %h",
                     instr_count, s_count, 16'(steps), 3'(steps));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if (byte_ready !== 1'b1 || step !== 1'b0 || out_valid !== 1'b0 || byte_out !== 8'h00 ||
            busy !== 1'b0 || instr !== 32'h0 || instr_count !== 16'h0) begin
            bad++;
            $display("FAIL reset: ready=%b step=%b ovalid=%b byte=%h busy=%b instr=%h cnt=%h required 1 0 0 00 0 0 0",
                     byte_ready, step, out_valid, byte_out, busy, instr, instr_count);
        end
    endtask

    task automatic test_addi;
        run_instr(32'h0050_0093, 0, 0, 0, 1'b0);
    endtask

    task automatic test_drain_hold;
        run_instr(32'h0050_0093, 0, 0, 3, 1'b0);
    endtask

    task automatic test_valid_while_busy;
        run_instr(32'h0030_0193, 0, 0, 0, 1'b1);
        run_instr(32'hDEAD_BEEF, 20, 0, 0, 1'b0);
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = 8'hFF;
        @(negedge clk);
        byte_in = 8'h77;
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        steps = 0;
        total++;
        if (byte_ready !== 1'b1 || busy !== 1'b0 || instr !== 32'h0 || instr_count !== 16'h0) begin
            bad++;
            $display("FAIL abort_reset: ready=%b busy=%b instr=%h cnt=%h required 1 0 0 0",
                     byte_ready, busy, instr, instr_count);
        end
        run_instr(32'h00A0_0113, 0, 0, 0, 1'b0);
    endtask

    task automatic test_count_wrap;
        for (int i = 0; i < 7; i++) run_instr(32'h1000_0013 + 32'(i), 10, 10, 0, 1'b0);
        total++;
        if (s_count !== 3'd0 || instr_count !== 16'd8) begin
            bad++;
            $display("FAIL count_wrap: small=%h cnt=%h required 0 0008", s_count, instr_count);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 100; i++)
            run_instr($urandom, 30, 30, 0, 1'($urandom_range(1)));
    endtask

    initial begin
        test_reset();
        test_addi();
        test_drain_hold();
        test_valid_while_busy();
        test_reset_abort();
        test_count_wrap();
        test_random();
        @(negedge clk);
        byte_valid = 1'b0;
        total++;
        if (exp_byte_q.size() != 0 || exp_instr_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: bytes=%0d instrs=%0d required 0 0",
                     exp_byte_q.size(), exp_instr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
